// File: rtl/uart_pkg.sv
// Shared types and constants for the UART store/echo loopback stage.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    localparam logic MODE_ECHO  = 1'b0;
    localparam logic MODE_STORE = 1'b1;

    localparam logic [7:0] TERM_CHAR_DEF = 8'h0D;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer with wrapping pointers and a registered read port
// addressed relative to the oldest entry.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              push_ok,
    output logic              pop_ok,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] rd_idx;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // full is taken before any same-cycle pop, so a byte arriving at full is dropped
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && push_ok)
            mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[ADDR_W-1:0]];

    // offset adds modulo DEPTH by truncation to ADDR_W bits
    assign rd_idx = rd_ptr[ADDR_W-1:0] + rd_addr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < count)
            rd_data <= mem[rd_idx];
        else
            rd_data <= '0;
    end

endmodule

// File: rtl/uart_store_loop.sv
// Buffered UART loopback: echoes bytes as the transmitter frees up, or stores
// them until a terminator / full buffer and then dumps the whole buffer.
module uart_store_loop
    import uart_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(TERM_CHAR_DEF),
    parameter int                LED_W     = 4,
    parameter int                BUSY_TO   = 15
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              mode,
    input  logic              clear,
    input  logic              recv_done,
    input  logic [DATA_W-1:0] recv_data,
    input  logic              tx_busy,
    output logic              send_en,
    output logic [DATA_W-1:0] send_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [LED_W-1:0]  led,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int              SEG     = DEPTH / LED_W;
    localparam int              TO_W    = $clog2(BUSY_TO + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);
    localparam logic [ADDR_W:0] ALMOST  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    tx_state_t         state, state_nxt;
    logic              mode_q;
    logic              dump_pending;
    logic [TO_W-1:0]   to_cnt;
    logic              launch;
    logic              pop;
    logic              push_ok, pop_ok;
    logic              full, empty;
    logic [DATA_W-1:0] head_data;
    logic              term_seen, fill_set, drained;

    uart_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .flush     (clear),
        .push      (recv_done),
        .push_data (recv_data),
        .pop       (pop),
        .rd_addr   (rd_addr),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .rd_data   (rd_data)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // a launch is held off while tx_busy is high so bytes never overlap on the line
    always_comb begin
        state_nxt = state;
        send_en   = 1'b0;
        pop       = 1'b0;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !clear && !tx_busy &&
                    (mode == MODE_ECHO || dump_pending)) begin
                    state_nxt = ISSUE;
                    launch    = 1'b1;
                end
            end
            ISSUE: begin
                send_en   = 1'b1;
                pop       = 1'b1;
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy)
                    state_nxt = WAIT_LO;
                else if (to_cnt == TO_LAST)
                    state_nxt = IDLE;
            end
            WAIT_LO: begin
                if (!tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            to_cnt <= '0;
        else if (state == ISSUE)
            to_cnt <= '0;
        else if (state == WAIT_HI)
            to_cnt <= to_cnt + 1'b1;
    end

    // send_data is captured at launch and held through the whole transmit
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            send_data <= '0;
            mode_q    <= MODE_ECHO;
        end else if (launch) begin
            send_data <= head_data;
            mode_q    <= mode;
        end
    end

    assign term_seen = recv_done && (recv_data == TERM_CHAR);
    assign fill_set  = push_ok && !pop_ok && (count == ALMOST);
    assign drained   = pop_ok && !push_ok && (count == ONE) && (mode_q == MODE_STORE);

    // a dropped terminator still triggers the dump
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            dump_pending <= 1'b0;
        else if (clear)
            dump_pending <= 1'b0;
        else if (mode == MODE_STORE && (term_seen || fill_set))
            dump_pending <= 1'b1;
        else if (drained)
            dump_pending <= 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if (recv_done && full)
            overflow <= 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            led <= '0;
        else
            for (int i = 0; i < LED_W; i++)
                led[i] <= (count > (ADDR_W+1)'(i * SEG));
    end

endmodule
